// File: rtl/line_draw_scheduler.sv
// line_draw_scheduler
//   Queues line commands from a requester and sequences a Bresenham line
//   drawer: loads each command's endpoints into the drawer, gates the drawer's
//   per-cycle pixel into framebuffer write strobes for exactly the pixels of
//   the line, and pulses cmd_done once per finished command.
//
//   Build option: define LD_SCHED_CLEAR_EN to turn cmd_clear=1 commands into a
//   full-screen clear (HEIGHT rows of WIDTH pixels). Without it cmd_clear is
//   ignored (stored as 0) and no row-counter logic exists.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (transfer on valid&&ready)
//   cmd_x0..cmd_y1, cmd_color    line endpoints and colour
//   cmd_clear                    clear-screen request (see build option)
//   ld_reset, ld_x0..ld_y1       drawer load strobe and endpoints
//   ld_x, ld_y                   drawer's current pixel
//   pix_we, pix_x, pix_y         framebuffer write strobe and address
//   pix_color                    colour of the active command
//   cmd_done                     one-cycle pulse after a command's last pixel
//   busy                         FSM not idle or queue non-empty
module line_draw_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_x0,
    input  logic [10:0] cmd_y0,
    input  logic [10:0] cmd_x1,
    input  logic [10:0] cmd_y1,
    input  logic        cmd_color,
    input  logic        cmd_clear,
    output logic        ld_reset,
    output logic [10:0] ld_x0,
    output logic [10:0] ld_y0,
    output logic [10:0] ld_x1,
    output logic [10:0] ld_y1,
    input  logic [10:0] ld_x,
    input  logic [10:0] ld_y,
    output logic        pix_we,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_color,
    output logic        cmd_done,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 46;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]    state_reg;
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [EW-1:0] push_entry;
    logic [10:0]   head_x0, head_y0, head_x1, head_y1;
    logic          head_color;
    logic          head_clear;
    logic [10:0]   x0_reg, y0_reg, x1_reg, y1_reg;
    logic          color_reg;
    logic [10:0]   remaining_reg;
    logic [10:0]   span;
    logic          last_row;

    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Queue: extra pointer bit distinguishes full from empty.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop        = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && !fifo_empty;
    // A pop in the same cycle frees the head slot, so a full queue still accepts.
    assign cmd_ready  = !fifo_full || pop;
    assign push       = cmd_valid && cmd_ready;

`ifdef LD_SCHED_CLEAR_EN
    localparam logic [10:0] X_LAST   = 11'(WIDTH - 1);
    localparam logic [10:0] ROW_LAST = 11'(HEIGHT - 1);
    logic        clear_reg;
    logic [10:0] row_reg;

    assign push_entry = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_clear};
    assign last_row   = !clear_reg || (row_reg == ROW_LAST);
`else
    logic unused_clear;

    assign push_entry   = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, 1'b0};
    assign last_row     = 1'b1;
    assign unused_clear = cmd_clear ^ head_clear;
`endif

    assign {head_x0, head_y0, head_x1, head_y1, head_color, head_clear} =
        fifo_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Pixel count minus one; DRAW counts it down to zero.
    assign span = (abs_diff(x1_reg, x0_reg) > abs_diff(y1_reg, y0_reg)) ?
                  abs_diff(x1_reg, x0_reg) : abs_diff(y1_reg, y0_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            x0_reg        <= '0;
            y0_reg        <= '0;
            x1_reg        <= '0;
            y1_reg        <= '0;
            color_reg     <= 1'b0;
            remaining_reg <= '0;
`ifdef LD_SCHED_CLEAR_EN
            clear_reg     <= 1'b0;
            row_reg       <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (pop) begin
                        color_reg <= head_color;
`ifdef LD_SCHED_CLEAR_EN
                        clear_reg <= head_clear;
                        row_reg   <= '0;
                        if (head_clear) begin
                            x0_reg <= '0;
                            y0_reg <= '0;
                            x1_reg <= X_LAST;
                            y1_reg <= '0;
                        end else begin
                            x0_reg <= head_x0;
                            y0_reg <= head_y0;
                            x1_reg <= head_x1;
                            y1_reg <= head_y1;
                        end
`else
                        x0_reg <= head_x0;
                        y0_reg <= head_y0;
                        x1_reg <= head_x1;
                        y1_reg <= head_y1;
`endif
                        state_reg <= ST_LOAD;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    remaining_reg <= span;
                    state_reg     <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (remaining_reg == 11'd0) begin
                        if (last_row) begin
                            state_reg <= ST_DONE;
                        end else begin
`ifdef LD_SCHED_CLEAR_EN
                            // Next clear row goes straight to its own LOAD.
                            row_reg <= row_reg + 11'd1;
                            y0_reg  <= row_reg + 11'd1;
                            y1_reg  <= row_reg + 11'd1;
`endif
                            state_reg <= ST_LOAD;
                        end
                    end else begin
                        remaining_reg <= remaining_reg - 11'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ld_reset  = (state_reg == ST_LOAD);
    assign ld_x0     = x0_reg;
    assign ld_y0     = y0_reg;
    assign ld_x1     = x1_reg;
    assign ld_y1     = y1_reg;
    assign pix_we    = (state_reg == ST_DRAW);
    assign pix_x     = ld_x;
    assign pix_y     = ld_y;
    assign pix_color = color_reg;
    assign cmd_done  = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Testbench for line_draw_scheduler with a behavioural Bresenham drawer on the
// ld_* ports. Expected pixels/loads/completions are queued at command issue and
// consumed by a monitor running at the falling clock edge.
module tb_line_draw_scheduler;
`ifdef LD_SCHED_CLEAR_EN
    localparam int W = 4;
    localparam int H = 2;
`else
    localparam int W = 640;
    localparam int H = 480;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic        cmd_color = 1'b0;
    logic        cmd_clear = 1'b0;
    logic        ld_reset;
    logic [10:0] ld_x0, ld_y0, ld_x1, ld_y1;
    logic [10:0] ld_x, ld_y;
    logic        pix_we;
    logic [10:0] pix_x, pix_y;
    logic        pix_color;
    logic        cmd_done;
    logic        busy;

    always #5 clk = ~clk;

    line_draw_scheduler #(.FIFO_DEPTH(DEPTH), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .cmd_clear(cmd_clear),
        .ld_reset(ld_reset),
        .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
        .ld_x(ld_x), .ld_y(ld_y),
        .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .cmd_done(cmd_done), .busy(busy)
    );

    // ---------------- behavioural line drawer ----------------
    typedef struct packed {
        int a; int b; int da; int db; int step; bit steep;
    } dinit_t;

    function automatic dinit_t drawer_init(input int x0, input int y0, input int x1, input int y1);
        dinit_t r;
        int a0, b0, a1, b1, t;
        r.steep = ((y1 > y0 ? y1 - y0 : y0 - y1) > (x1 > x0 ? x1 - x0 : x0 - x1));
        a0 = r.steep ? y0 : x0; b0 = r.steep ? x0 : y0;
        a1 = r.steep ? y1 : x1; b1 = r.steep ? x1 : y1;
        if (a0 > a1) begin
            t = a0; a0 = a1; a1 = t;
            t = b0; b0 = b1; b1 = t;
        end
        r.a = a0; r.b = b0; r.da = a1 - a0;
        r.db = (b1 > b0) ? b1 - b0 : b0 - b1;
        r.step = (b1 > b0) ? 1 : -1;
        return r;
    endfunction

    dinit_t d_new;
    int d_a = 0, d_b = 0, d_da = 0, d_db = 0, d_step = 1, d_err = 0;
    bit d_steep = 1'b0;
    assign d_new = drawer_init(int'(ld_x0), int'(ld_y0), int'(ld_x1), int'(ld_y1));

    always @(posedge clk) begin
        if (ld_reset) begin
            d_a <= d_new.a; d_b <= d_new.b; d_da <= d_new.da; d_db <= d_new.db;
            d_step <= d_new.step; d_steep <= d_new.steep; d_err <= 0;
        end else begin
            d_a   <= d_a + 1;
            d_b   <= (d_err - d_db < 0) ? d_b + d_step : d_b;
            d_err <= (d_err - d_db < 0) ? d_err - d_db + d_da : d_err - d_db;
        end
    end
    assign ld_x = d_steep ? 11'(d_b) : 11'(d_a);
    assign ld_y = d_steep ? 11'(d_a) : 11'(d_b);

    // ---------------- scoreboard ----------------
    typedef struct { bit is_done; int x; int y; bit color; } ev_t;
    typedef struct { int x0; int y0; int x1; int y1; } ld_t;
    ev_t exp_q[$];
    ld_t load_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dones = 0;
    int done_cyc = 0;
    bit gap_en = 1'b0;
    bit gap_pending = 1'b0;
    bit first_due = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_pix(input int x, input int y, input bit c);
        exp_q.push_back('{1'b0, x, y, c});
    endtask
    task automatic add_done();
        exp_q.push_back('{1'b1, 0, 0, 1'b0});
    endtask
    task automatic add_load(input int x0, input int y0, input int x1, input int y1);
        load_q.push_back('{x0, y0, x1, y1});
    endtask

    // Reference: step along the major axis; minor coordinate after k steps is
    // offset by ceil(k*minor/major) toward the far end.
    task automatic expect_line(input int x0, input int y0, input int x1, input int y1, input bit c);
        int dx, dy, a0, b0, a1, b1, t, n, m, s, b;
        bit steep;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y1 - y0 : y0 - y1;
        steep = dy > dx;
        a0 = steep ? y0 : x0; b0 = steep ? x0 : y0;
        a1 = steep ? y1 : x1; b1 = steep ? x1 : y1;
        if (a0 > a1) begin
            t = a0; a0 = a1; a1 = t;
            t = b0; b0 = b1; b1 = t;
        end
        n = a1 - a0;
        m = (b1 > b0) ? b1 - b0 : b0 - b1;
        s = (b1 >= b0) ? 1 : -1;
        add_load(x0, y0, x1, y1);
        for (int k = 0; k <= n; k++) begin
            b = b0 + s * ((n == 0) ? 0 : (k * m + n - 1) / n);
            if (steep) add_pix(b, a0 + k, c);
            else       add_pix(a0 + k, b, c);
        end
        add_done();
    endtask

`ifdef LD_SCHED_CLEAR_EN
    task automatic expect_clear(input bit c);
        for (int r = 0; r < H; r++) begin
            add_load(0, r, W - 1, r);
            for (int x = 0; x < W; x++) add_pix(x, r, c);
        end
        add_done();
    endtask
`endif

    task automatic monitor_loop();
        ev_t e;
        ld_t l;
        forever begin
            @(negedge clk);
            cyc++;
            if (first_due) begin
                check(pix_we == 1'b1, "load_then_draw", int'(pix_we), 1);
                first_due = 1'b0;
            end
            if (ld_reset) begin
                check(load_q.size() > 0, "load_unexpected", int'(ld_x0), -1);
                if (load_q.size() > 0) begin
                    l = load_q.pop_front();
                    check(int'(ld_x0) == l.x0, "ld_x0", int'(ld_x0), l.x0);
                    check(int'(ld_y0) == l.y0, "ld_y0", int'(ld_y0), l.y0);
                    check(int'(ld_x1) == l.x1, "ld_x1", int'(ld_x1), l.x1);
                    check(int'(ld_y1) == l.y1, "ld_y1", int'(ld_y1), l.y1);
                end
                first_due = 1'b1;
            end
            if (pix_we) begin
                if (gap_pending) begin
                    check(cyc - done_cyc == 2, "line_gap", cyc - done_cyc, 2);
                    gap_pending = 1'b0;
                end
                check(exp_q.size() > 0, "pixel_unexpected", int'(pix_x), -1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(!e.is_done, "pixel_order", 1, 0);
                    check(int'(pix_x) == e.x, "pix_x", int'(pix_x), e.x);
                    check(int'(pix_y) == e.y, "pix_y", int'(pix_y), e.y);
                    check(pix_color == e.color, "pix_color", int'(pix_color), int'(e.color));
                    $display("pixel (%0d,%0d) color %0d", pix_x, pix_y, pix_color);
                end
            end
            if (cmd_done) begin
                dones++;
                done_cyc = cyc;
                gap_pending = gap_en;
                check(exp_q.size() > 0, "done_unexpected", 1, 0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(e.is_done, "done_order", 0, 1);
                    $display("cmd_done at cycle %0d", cyc);
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic send(input int x0, input int y0, input int x1, input int y1,
                        input bit c, input bit clr);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        cmd_x0 = 11'(x0); cmd_y0 = 11'(y0); cmd_x1 = 11'(x1); cmd_y1 = 11'(y1);
        cmd_color = c; cmd_clear = clr; cmd_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        check(got, "send_accept", int'(got), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
        $display("cmd (%0d,%0d)-(%0d,%0d) color %0d clear %0d accepted=%0d", x0, y0, x1, y1, c, clr, got);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(n < budget, "idle_timeout", n, budget);
        @(negedge clk);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    endtask

    function automatic int near(input int v);
        int lo, hi;
        lo = (v < 12) ? 0 : v - 12;
        hi = (v > 2035) ? 2047 : v + 12;
        return int'($urandom_range(hi, lo));
    endfunction

    initial begin
        int n, d0, x0, y0;
        bit seen;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(cmd_ready == 1'b1, "rst_cmd_ready", int'(cmd_ready), 1);
        check(busy == 1'b0, "rst_busy", int'(busy), 0);
        check(pix_we == 1'b0, "rst_pix_we", int'(pix_we), 0);
        check(cmd_done == 1'b0, "rst_cmd_done", int'(cmd_done), 0);
        check(ld_reset == 1'b0, "rst_ld_reset", int'(ld_reset), 0);
        check(pix_color == 1'b0, "rst_pix_color", int'(pix_color), 0);
        check((ld_x0 | ld_y0 | ld_x1 | ld_y1) == 11'd0, "rst_ld_endpoints",
              int'(ld_x0 | ld_y0 | ld_x1 | ld_y1), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Horizontal line
        add_load(0, 0, 3, 0);
        add_pix(0, 0, 1); add_pix(1, 0, 1); add_pix(2, 0, 1); add_pix(3, 0, 1);
        add_done();
        send(0, 0, 3, 0, 1'b1, 1'b0);
        wait_idle(200);

        // Right-to-left shallow line and steep upward line
        add_load(5, 0, 2, 2);
        add_pix(2, 2, 0); add_pix(3, 1, 0); add_pix(4, 0, 0); add_pix(5, 0, 0);
        add_done();
        send(5, 0, 2, 2, 1'b0, 1'b0);
        add_load(0, 3, 0, 0);
        add_pix(0, 0, 1); add_pix(0, 1, 1); add_pix(0, 2, 1); add_pix(0, 3, 1);
        add_done();
        send(0, 3, 0, 0, 1'b1, 1'b0);
        wait_idle(200);

        // Degenerate single-pixel line
        expect_line(7, 9, 7, 9, 1'b1);
        send(7, 9, 7, 9, 1'b1, 1'b0);
        wait_idle(200);

        // Queue fill while drawing a long line
        d0 = dones;
        gap_en = 1'b1;
        expect_line(0, 0, 39, 0, 1'b1);
        send(0, 0, 39, 0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = pix_we;
        end
        check(seen, "long_line_started", int'(seen), 1);
        for (int i = 0; i < DEPTH; i++) begin
            expect_line(i, 5, i + 3, 7 - i, 1'(i));
            send(i, 5, i + 3, 7 - i, 1'(i), 1'b0);
        end
        @(negedge clk);
        check(cmd_ready == 1'b0, "ready_when_full", int'(cmd_ready), 0);
        check(busy == 1'b1, "busy_when_full", int'(busy), 1);
        expect_line(20, 2, 14, 11, 1'b0);
        send(20, 2, 14, 11, 1'b0, 1'b0);
        wait_idle(500);
        gap_en = 1'b0;
        gap_pending = 1'b0;
        check(dones - d0 == DEPTH + 2, "done_count_fill", dones - d0, DEPTH + 2);

        // Reset in the middle of a line
        d0 = dones;
        expect_line(0, 0, 9, 9, 1'b1);
        send(0, 0, 9, 9, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = pix_we;
        end
        check(seen, "diag_started", int'(seen), 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        load_q.delete();
        reset_n = 1'b1;
        @(negedge clk);
        check(pix_we == 1'b0, "abort_pix_we", int'(pix_we), 0);
        check(busy == 1'b0, "abort_busy", int'(busy), 0);
        check(cmd_ready == 1'b1, "abort_ready", int'(cmd_ready), 1);
        repeat (20) @(negedge clk);
        check(dones == d0, "abort_no_done", dones - d0, 0);

        // Clear request
`ifdef LD_SCHED_CLEAR_EN
        d0 = dones;
        expect_clear(1'b0);
        send(7, 7, 7, 7, 1'b0, 1'b1);
        wait_idle(200);
        check(dones - d0 == 1, "clear_done_count", dones - d0, 1);
`else
        expect_line(1, 1, 3, 2, 1'b0);
        send(1, 1, 3, 2, 1'b0, 1'b1);
        wait_idle(200);
`endif

        // Random lines, including far-off-screen coordinates
        for (int i = 0; i < 30; i++) begin
            n = int'($urandom_range(3, 0));
            repeat (n) @(posedge clk);
            x0 = int'($urandom_range(2047, 0));
            y0 = int'($urandom_range(2047, 0));
            if (i % 2 == 0) begin
                x0 = x0 % 24;
                y0 = y0 % 24;
            end
            begin
                int x1, y1;
                bit c;
                x1 = near(x0);
                y1 = near(y0);
                c = 1'($urandom_range(1, 0));
                expect_line(x0, y0, x1, y1, c);
                send(x0, y0, x1, y1, c, 1'b0);
            end
        end
        wait_idle(5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
